// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched
//   Byte-level TX scheduler ahead of the paralelo_serial converter in phy_tx.
//   After reset, or after a retrain request, it emits a burst of NUM_COM COM
//   symbols. It then arbitrates two byte requesters round-robin onto one 8-bit
//   symbol stream, fills empty cycles with IDLE and inserts a COM skip symbol
//   on the last cycle of every SKP_INTERVAL-cycle period.
//   Optional feature macro: PHY_TX_CTRL_STATS_EN adds saturating per-lane
//   accepted-byte counters (count0_out/count1_out).
module phy_tx_lane_sched #(
    parameter logic [7:0]  COM_SYM      = 8'hBC,
    parameter logic [7:0]  IDLE_SYM     = 8'h7C,
    parameter int unsigned NUM_COM      = 4,
    parameter int unsigned SKP_INTERVAL = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic [7:0]       data0_in,
    input  logic             valid0_in,
    output logic             ready0_out,
    input  logic [7:0]       data1_in,
    input  logic             valid1_in,
    output logic             ready1_out,
    input  logic             retrain_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             active_out
`ifdef PHY_TX_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] count0_out,
    output logic [CNT_W-1:0] count1_out
`endif
);

    localparam int unsigned        TRAIN_W    = (NUM_COM > 1) ? $clog2(NUM_COM) : 1;
    localparam int unsigned        SKP_W      = $clog2(SKP_INTERVAL);
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(NUM_COM - 1);
    localparam logic [SKP_W-1:0]   SKP_LAST   = SKP_W'(SKP_INTERVAL - 1);

    localparam logic [0:0] ST_TRAIN  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Reject configurations the counters and arbitration cannot honour.
    generate
        if (NUM_COM < 1) begin : g_bad_num_com
            $error("phy_tx_lane_sched: NUM_COM must be >= 1");
        end
        if (SKP_INTERVAL < 2) begin : g_bad_skp_interval
            $error("phy_tx_lane_sched: SKP_INTERVAL must be >= 2");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("phy_tx_lane_sched: CNT_W must be >= 1");
        end
    endgenerate

    logic [0:0]         state;
    logic [TRAIN_W-1:0] train_cnt;
    logic [SKP_W-1:0]   skp_cnt;
    logic               last;        // lane of the most recent transfer

    logic               skip_cyc;
    logic               grant_any;
    logic               grant_lane;
    logic               lane_open;
    logic               xfer0;
    logic               xfer1;

    // Skip cycle: last ACTIVE cycle of each skip period.
    always_comb begin
        skip_cyc = (state == ST_ACTIVE) && (skp_cnt == SKP_LAST);
    end

    // Round-robin pick: a lone requester wins, a tie goes to the lane not served last.
    always_comb begin
        grant_any = valid0_in || valid1_in;
        if (valid0_in && valid1_in) begin
            grant_lane = ~last;
        end else begin
            grant_lane = valid1_in;
        end
    end

    // Handshake: the stream is open only in ACTIVE, outside skip, with no retrain pending.
    always_comb begin
        lane_open  = (state == ST_ACTIVE) && !skip_cyc && !retrain_in;
        ready0_out = lane_open && grant_any && !grant_lane;
        ready1_out = lane_open && grant_any &&  grant_lane;
    end

    // Accepted byte per lane; a grant is only ever given to a valid requester.
    always_comb begin
        xfer0 = valid0_in && ready0_out;
        xfer1 = valid1_in && ready1_out;
    end

    // Link state, training burst length and skip period position.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_TRAIN;
            train_cnt <= '0;
            skp_cnt   <= '0;
        end else if (retrain_in) begin
            state     <= ST_TRAIN;
            train_cnt <= '0;
            skp_cnt   <= '0;
        end else if (state == ST_TRAIN) begin
            skp_cnt <= '0;
            if (train_cnt == TRAIN_LAST) begin
                state     <= ST_ACTIVE;
                train_cnt <= '0;
            end else begin
                train_cnt <= train_cnt + 1'b1;
            end
        end else begin
            if (skip_cyc) begin
                skp_cnt <= '0;
            end else begin
                skp_cnt <= skp_cnt + 1'b1;
            end
        end
    end

    // Arbitration history; untouched by retrain so fairness carries across a burst.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            last <= 1'b1;
        end else if (xfer0) begin
            last <= 1'b0;
        end else if (xfer1) begin
            last <= 1'b1;
        end
    end

    // Registered symbol stream to the serializer.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= COM_SYM;
            valid_out <= 1'b0;
        end else if (retrain_in || (state == ST_TRAIN) || skip_cyc) begin
            data_out  <= COM_SYM;
            valid_out <= 1'b0;
        end else if (xfer0) begin
            data_out  <= data0_in;
            valid_out <= 1'b1;
        end else if (xfer1) begin
            data_out  <= data1_in;
            valid_out <= 1'b1;
        end else begin
            data_out  <= IDLE_SYM;
            valid_out <= 1'b0;
        end
    end

    // Link-up flag, aligned with the symbol produced by the same ACTIVE cycle.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            active_out <= 1'b0;
        end else begin
            active_out <= (state == ST_ACTIVE) && !retrain_in;
        end
    end

`ifdef PHY_TX_CTRL_STATS_EN
    // Saturating accepted-byte counters; only reset_L clears them.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            count0_out <= '0;
            count1_out <= '0;
        end else begin
            if (xfer0 && (count0_out != '1)) begin
                count0_out <= count0_out + 1'b1;
            end
            if (xfer1 && (count1_out != '1)) begin
                count1_out <= count1_out + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Directed self-checking bench for phy_tx_lane_sched (NUM_COM=4, SKP_INTERVAL=16, CNT_W=4).
// Stats checks are compiled in only when PHY_TX_CTRL_STATS_EN is defined.
module tb_phy_tx_lane_sched;

    logic       clk_4f;
    logic       reset_L;
    logic [7:0] data0_in;
    logic       valid0_in;
    logic       ready0_out;
    logic [7:0] data1_in;
    logic       valid1_in;
    logic       ready1_out;
    logic       retrain_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
`ifdef PHY_TX_CTRL_STATS_EN
    logic [3:0] count0_out;
    logic [3:0] count1_out;
`endif

    int n_cmp;
    int n_fail;

    phy_tx_lane_sched #(
        .COM_SYM     (8'hBC),
        .IDLE_SYM    (8'h7C),
        .NUM_COM     (4),
        .SKP_INTERVAL(16),
        .CNT_W       (4)
    ) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data0_in  (data0_in),
        .valid0_in (valid0_in),
        .ready0_out(ready0_out),
        .data1_in  (data1_in),
        .valid1_in (valid1_in),
        .ready1_out(ready1_out),
        .retrain_in(retrain_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active_out(active_out)
`ifdef PHY_TX_CTRL_STATS_EN
        ,
        .count0_out(count0_out),
        .count1_out(count1_out)
`endif
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    // Advance one clock; resume 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    // Pulse retrain and wait out the burst; returns in the first ACTIVE cycle (skip slot 0).
    task automatic resync();
        valid0_in  = 1'b0;
        valid1_in  = 1'b0;
        retrain_in = 1'b1;
        tick();
        retrain_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        valid0_in = 1'b1; data0_in = 8'h11;
        valid1_in = 1'b1; data1_in = 8'h22;
        retrain_in = 1'b0;
        repeat (2) tick();
        n_cmp++; if (data_out !== 8'hBC) begin n_fail++; $display("FAIL reset_data: got %h want bc", data_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active_out); end
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {ready0_out, ready1_out}); end
`ifdef PHY_TX_CTRL_STATS_EN
        n_cmp++; if ({count0_out, count1_out} !== 8'h00) begin n_fail++; $display("FAIL reset_counts: got %h want 00", {count0_out, count1_out}); end
`endif
        reset_L = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if ({ready0_out, ready1_out} !== 2'b00) begin n_fail++; $display("FAIL train_ready[%0d]: got %b want 00", k, {ready0_out, ready1_out}); end
            tick();
            n_cmp++; if ({data_out, valid_out, active_out} !== {8'hBC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL train_sym[%0d]: got %h/%b/%b want bc/0/0", k, data_out, valid_out, active_out); end
        end
        valid0_in = 1'b0;
        valid1_in = 1'b0;
        tick();
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'h7C, 1'b0, 1'b1}) begin n_fail++; $display("FAIL first_active: got %h/%b/%b want 7c/0/1", data_out, valid_out, active_out); end
    endtask

    task automatic test_single();
        resync();
        valid0_in = 1'b1; data0_in = 8'hAA;
        #1;
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b10) begin n_fail++; $display("FAIL single0_ready: got %b want 10", {ready0_out, ready1_out}); end
        tick();
        valid0_in = 1'b0;
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'hAA, 1'b1, 1'b1}) begin n_fail++; $display("FAIL single0_data: got %h/%b/%b want aa/1/1", data_out, valid_out, active_out); end
        valid1_in = 1'b1; data1_in = 8'h55;
        #1;
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b01) begin n_fail++; $display("FAIL single1_ready: got %b want 01", {ready0_out, ready1_out}); end
        tick();
        valid1_in = 1'b0;
        n_cmp++; if ({data_out, valid_out} !== {8'h55, 1'b1}) begin n_fail++; $display("FAIL single1_data: got %h/%b want 55/1", data_out, valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic       even;
        resync();
        valid0_in = 1'b1; data0_in = 8'hCC;
        valid1_in = 1'b1; data1_in = 8'hDD;
        for (int unsigned i = 0; i < 4; i++) begin
            even  = (i % 2 == 0);
            exp_d = even ? 8'hCC : 8'hDD;
            #1;
            n_cmp++; if ({ready0_out, ready1_out} !== {even, ~even}) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, {ready0_out, ready1_out}, {even, ~even}); end
            n_cmp++; if ((ready0_out & ready1_out) !== 1'b0) begin n_fail++; $display("FAIL b2b_both_ready[%0d]: got 1 want 0", i); end
            tick();
            n_cmp++; if ({data_out, valid_out} !== {exp_d, 1'b1}) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/1", i, data_out, valid_out, exp_d); end
        end
        valid0_in = 1'b0;
        valid1_in = 1'b0;
    endtask

    task automatic test_retrain();
        resync();
        valid0_in = 1'b1; data0_in = 8'hCC;
        valid1_in = 1'b1; data1_in = 8'hDD;
        #1;
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b10) begin n_fail++; $display("FAIL rt_pre_ready0: got %b want 10", {ready0_out, ready1_out}); end
        tick();
        n_cmp++; if ({data_out, valid_out} !== {8'hCC, 1'b1}) begin n_fail++; $display("FAIL rt_pre_data: got %h/%b want cc/1", data_out, valid_out); end
        #1;
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b01) begin n_fail++; $display("FAIL rt_pre_ready1: got %b want 01", {ready0_out, ready1_out}); end
        retrain_in = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if ({ready0_out, ready1_out} !== 2'b00) begin n_fail++; $display("FAIL rt_hold_ready[%0d]: got %b want 00", k, {ready0_out, ready1_out}); end
            tick();
            n_cmp++; if ({data_out, valid_out, active_out} !== {8'hBC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rt_hold_sym[%0d]: got %h/%b/%b want bc/0/0", k, data_out, valid_out, active_out); end
        end
        retrain_in = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if ({ready0_out, ready1_out} !== 2'b00) begin n_fail++; $display("FAIL rt_train_ready[%0d]: got %b want 00", k, {ready0_out, ready1_out}); end
            tick();
            n_cmp++; if ({data_out, valid_out, active_out} !== {8'hBC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rt_train_sym[%0d]: got %h/%b/%b want bc/0/0", k, data_out, valid_out, active_out); end
        end
        #1;
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b01) begin n_fail++; $display("FAIL rt_resume_ready: got %b want 01", {ready0_out, ready1_out}); end
        tick();
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'hDD, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rt_resume_data: got %h/%b/%b want dd/1/1", data_out, valid_out, active_out); end
        valid0_in = 1'b0;
        valid1_in = 1'b0;
    endtask

    task automatic test_idle_skip();
        logic       v;
        logic       skp;
        logic [7:0] exp_d;
        resync();
        data0_in = 8'hA5;
        for (int unsigned i = 0; i < 32; i++) begin
            v   = (i == 15) || (i == 16);
            skp = (i % 16 == 15);
            valid0_in = v;
            exp_d = skp ? 8'hBC : (v ? 8'hA5 : 8'h7C);
            #1;
            n_cmp++; if ({ready0_out, ready1_out} !== {v & ~skp, 1'b0}) begin n_fail++; $display("FAIL idle_ready[%0d]: got %b want %b", i, {ready0_out, ready1_out}, {v & ~skp, 1'b0}); end
            tick();
            n_cmp++; if ({data_out, valid_out, active_out} !== {exp_d, v & ~skp, 1'b1}) begin n_fail++; $display("FAIL idle_sym[%0d]: got %h/%b/%b want %h/%b/1", i, data_out, valid_out, active_out, exp_d, v & ~skp); end
        end
        valid0_in = 1'b0;
    endtask

    task automatic test_async_reset();
        resync();
        valid0_in = 1'b1; data0_in = 8'h3C;
        tick();
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'h3C, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ar_pre: got %h/%b/%b want 3c/1/1", data_out, valid_out, active_out); end
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'hBC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ar_immediate: got %h/%b/%b want bc/0/0", data_out, valid_out, active_out); end
        n_cmp++; if ({ready0_out, ready1_out} !== 2'b00) begin n_fail++; $display("FAIL ar_ready: got %b want 00", {ready0_out, ready1_out}); end
        tick();
        reset_L = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (ready0_out !== 1'b0) begin n_fail++; $display("FAIL ar_train_ready[%0d]: got %b want 0", k, ready0_out); end
            tick();
            n_cmp++; if ({data_out, valid_out, active_out} !== {8'hBC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ar_train_sym[%0d]: got %h/%b/%b want bc/0/0", k, data_out, valid_out, active_out); end
        end
        tick();
        n_cmp++; if ({data_out, valid_out, active_out} !== {8'h3C, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ar_resume: got %h/%b/%b want 3c/1/1", data_out, valid_out, active_out); end
        valid0_in = 1'b0;
    endtask

`ifdef PHY_TX_CTRL_STATS_EN
    task automatic test_stats();
        reset_L = 1'b0;
        #1;
        n_cmp++; if ({count0_out, count1_out} !== 8'h00) begin n_fail++; $display("FAIL st_clear: got %h want 00", {count0_out, count1_out}); end
        tick();
        reset_L = 1'b1;
        repeat (4) tick();
        valid0_in = 1'b1; data0_in = 8'h11;
        for (int unsigned i = 0; i < 22; i++) begin
            tick();
            if (i == 4) begin
                n_cmp++; if (count0_out !== 4'd5) begin n_fail++; $display("FAIL st_count0_mid: got %0d want 5", count0_out); end
            end
        end
        valid0_in = 1'b0;
        n_cmp++; if (count0_out !== 4'd15) begin n_fail++; $display("FAIL st_count0_sat: got %0d want 15", count0_out); end
        n_cmp++; if (count1_out !== 4'd0) begin n_fail++; $display("FAIL st_count1: got %0d want 0", count1_out); end
        retrain_in = 1'b1;
        tick();
        retrain_in = 1'b0;
        tick();
        n_cmp++; if ({count0_out, count1_out} !== 8'hF0) begin n_fail++; $display("FAIL st_retrain_keep: got %h want f0", {count0_out, count1_out}); end
        reset_L = 1'b0;
        #1;
        n_cmp++; if ({count0_out, count1_out} !== 8'h00) begin n_fail++; $display("FAIL st_reset_clear: got %h want 00", {count0_out, count1_out}); end
        tick();
        reset_L = 1'b1;
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_retrain();
        test_idle_skip();
        test_async_reset();
`ifdef PHY_TX_CTRL_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
